cordic_rtop_sched: RTL and testbench

Round-robin scheduler that shares one fully pipelined rectangular-to-polar CORDIC (fixed latency LAT, clock enable tied high) between NREQ sample sources.
- Accepts at most one X/Y pair per cycle from the requesters via valid/ready.
- Tags each issued pair with its channel number and carries the tag alongside the CORDIC pipeline.
- Captures each result into a credit-protected output FIFO, so downstream backpressure never stalls or overruns the CORDIC.
- Sits between the per-channel sample front-ends and the magnitude/phase consumers.

---
 rtl/cordic_rtop_sched_pkg.sv | 36 +++
 rtl/sync_fifo_fwft.sv | 70 +++++++
 rtl/cordic_rtop_sched.sv | 144 ++++++++++++++
 tb/tb_cordic_rtop_sched.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_rtop_sched_pkg.sv
//----------------------------------------------------------------------------
// Module  : cordic_rtop_sched_pkg
// Purpose : Shared types, defaults and round-robin helpers for the CORDIC
//           rectangular-to-polar scheduler.
// Rev     : 1.0
//----------------------------------------------------------------------------
`default_nettype none

package cordic_rtop_sched_pkg;

  localparam int NREQ_DEF       = 4;
  localparam int IW_DEF         = 14;
  localparam int OW_DEF         = 10;
  localparam int LAT_DEF        = 15;
  localparam int FIFO_DEPTH_DEF = 32;

  typedef struct packed {
    logic [$clog2(NREQ_DEF)-1:0] chan;
    logic [OW_DEF-1:0]           mag;
    logic [OW_DEF-1:0]           phase;
  } res_rec_t;

  // Channel index 'off' positions after 'base', wrapping modulo nreq.
  function automatic int rr_wrap(input int base, input int off, input int nreq);
    int s;
    s = base + off;
    return (s >= nreq) ? s - nreq : s;
  endfunction

  function automatic int rr_next(input int chan, input int nreq);
    return rr_wrap(chan, 1, nreq);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo_fwft.sv
//----------------------------------------------------------------------------
// Module  : sync_fifo_fwft
// Purpose : Synchronous first-word-fall-through FIFO with occupancy count.
// Rev     : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module sync_fifo_fwft
  import cordic_rtop_sched_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int CNTW  = $clog2(DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_empty,
  output logic             o_full,
  output logic [CNTW-1:0]  o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             do_wr, do_rd;

  always_comb begin
    o_empty  = (count_q == '0);
    o_full   = (count_q == CNTW'(DEPTH));
    do_wr    = i_wr_en & ~o_full;
    do_rd    = i_rd_en & ~o_empty;
    wr_ptr_d = do_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
    unique case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only entries behind a valid count are ever read.
  always_ff @(posedge i_clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= i_wr_data;
  end

  assign o_rd_data = mem_q[rd_ptr_q];
  assign o_count   = count_q;

endmodule

`default_nettype wire

// File: rtl/cordic_rtop_sched.sv
//----------------------------------------------------------------------------
// Module  : cordic_rtop_sched
// Purpose : Round-robin, credit-protected scheduler sharing one pipelined
//           rectangular-to-polar CORDIC between NREQ sample channels.
// Rev     : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module cordic_rtop_sched
  import cordic_rtop_sched_pkg::*;
#(
  parameter int NREQ       = NREQ_DEF,
  parameter int IW         = IW_DEF,
  parameter int OW         = OW_DEF,
  parameter int LAT        = LAT_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int CW         = $clog2(NREQ)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NREQ-1:0]   i_req_valid,
  output logic [NREQ-1:0]   o_req_ready,
  input  logic [NREQ*IW-1:0] i_req_x,
  input  logic [NREQ*IW-1:0] i_req_y,
  output logic [IW-1:0]     o_cordic_x,
  output logic [IW-1:0]     o_cordic_y,
  output logic              o_cordic_ce,
  input  logic [OW-1:0]     i_cordic_mag,
  input  logic [OW-1:0]     i_cordic_phase,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic [CW-1:0]     o_res_chan,
  output logic [OW-1:0]     o_res_mag,
  output logic [OW-1:0]     o_res_phase,
  output logic              o_busy
);

  localparam int CRW = $clog2(FIFO_DEPTH) + 1;
  localparam int RW  = CW + 2 * OW;

  if (FIFO_DEPTH < LAT + 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || NREQ < 2 || NREQ > 8)
  begin : g_cfg_check
    $error("cordic_rtop_sched: illegal NREQ/FIFO_DEPTH/LAT combination");
  end

  logic [CRW-1:0] credit_q, credit_d;
  logic [CW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]  cx_q, cx_d, cy_q, cy_d;
  logic [LAT:0]   tag_vld_q, tag_vld_d;
  logic [CW-1:0]  tag_chan_q [LAT+1];
  logic [CW-1:0]  tag_chan_d [LAT+1];

  logic [CW-1:0]  cand, grant_idx;
  logic           grant_any, pop, fifo_wr, fifo_empty, fifo_full;
  logic [RW-1:0]  fifo_rd_data;
  logic [CRW-1:0] fifo_count;

  // Scan offsets from farthest to nearest so the nearest asserted request wins.
  always_comb begin
    cand        = '0;
    grant_idx   = '0;
    grant_any   = 1'b0;
    if (credit_q != '0) begin
      for (int off = NREQ - 1; off >= 0; off--) begin
        cand = CW'(rr_wrap(int'(rr_ptr_q), off, NREQ));
        if (i_req_valid[cand]) begin
          grant_idx = cand;
          grant_any = 1'b1;
        end
      end
    end
    o_req_ready = grant_any ? (NREQ'(1) << grant_idx) : '0;
  end

  always_comb begin
    pop      = ~fifo_empty & i_res_ready;
    credit_d = credit_q;
    if (grant_any && !pop)      credit_d = credit_q - CRW'(1);
    else if (!grant_any && pop) credit_d = credit_q + CRW'(1);
    rr_ptr_d = grant_any ? CW'(rr_next(int'(grant_idx), NREQ)) : rr_ptr_q;
    cx_d     = grant_any ? i_req_x[int'(grant_idx)*IW +: IW] : cx_q;
    cy_d     = grant_any ? i_req_y[int'(grant_idx)*IW +: IW] : cy_q;
    // Stage 0 sits beside the CORDIC input register; stages 1..LAT track its latency.
    tag_vld_d     = {tag_vld_q[LAT-1:0], grant_any};
    tag_chan_d[0] = grant_idx;
    for (int k = 1; k <= LAT; k++) tag_chan_d[k] = tag_chan_q[k-1];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      credit_q  <= CRW'(FIFO_DEPTH);
      rr_ptr_q  <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
      tag_vld_q <= '0;
      for (int k = 0; k <= LAT; k++) tag_chan_q[k] <= '0;
    end else begin
      credit_q  <= credit_d;
      rr_ptr_q  <= rr_ptr_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      tag_vld_q <= tag_vld_d;
      for (int k = 0; k <= LAT; k++) tag_chan_q[k] <= tag_chan_d[k];
    end
  end

  assign fifo_wr = tag_vld_q[LAT];

  sync_fifo_fwft #(
    .WIDTH (RW),
    .DEPTH (FIFO_DEPTH),
    .CNTW  (CRW)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_wr_en   (fifo_wr),
    .i_wr_data ({tag_chan_q[LAT], i_cordic_mag, i_cordic_phase}),
    .i_rd_en   (pop),
    .o_rd_data (fifo_rd_data),
    .o_empty   (fifo_empty),
    .o_full    (fifo_full),
    .o_count   (fifo_count)
  );

  // Credit accounting must keep the FIFO from ever being written while full.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      assert (!(fifo_wr && fifo_full));
      assert (32'(fifo_count) + 32'(credit_q) <= 32'(FIFO_DEPTH));
    end
  end

  assign o_cordic_x  = cx_q;
  assign o_cordic_y  = cy_q;
  assign o_cordic_ce = 1'b1;
  assign o_res_valid = ~fifo_empty;
  assign o_res_chan  = fifo_rd_data[2*OW +: CW];
  assign o_res_mag   = fifo_rd_data[OW +: OW];
  assign o_res_phase = fifo_rd_data[0 +: OW];
  assign o_busy      = (credit_q != CRW'(FIFO_DEPTH));

endmodule

`default_nettype wire

// File: tb/tb_cordic_rtop_sched.sv
//----------------------------------------------------------------------------
// Module  : tb_cordic_rtop_sched
// Purpose : Directed plus randomized bench for cordic_rtop_sched against a
//           queue-based scheduling/latency reference model.
// Rev     : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_cordic_rtop_sched;

  localparam int NREQ  = 4;
  localparam int IW    = 14;
  localparam int OW    = 10;
  localparam int LAT   = 15;
  localparam int DEPTH = 32;
  localparam int CW    = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*IW-1:0] req_x, req_y;
  logic [IW-1:0]      cx, cy;
  logic               ce;
  logic [OW-1:0]      mag, phase;
  logic               res_valid, res_ready, busy;
  logic [CW-1:0]      res_chan;
  logic [OW-1:0]      res_mag, res_phase;

  always #5 clk = ~clk;

  cordic_rtop_sched dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_x        (req_x),
    .i_req_y        (req_y),
    .o_cordic_x     (cx),
    .o_cordic_y     (cy),
    .o_cordic_ce    (ce),
    .i_cordic_mag   (mag),
    .i_cordic_phase (phase),
    .o_res_valid    (res_valid),
    .i_res_ready    (res_ready),
    .o_res_chan     (res_chan),
    .o_res_mag      (res_mag),
    .o_res_phase    (res_phase),
    .o_busy         (busy)
  );

  // CORDIC stand-in: LAT-cycle delay line, mag/phase are the low bits of x/y.
  logic [IW-1:0] dx [LAT];
  logic [IW-1:0] dy [LAT];
  always @(posedge clk) begin
    dx[0] <= cx;
    dy[0] <= cy;
    for (int k = 1; k < LAT; k++) begin
      dx[k] <= dx[k-1];
      dy[k] <= dy[k-1];
    end
  end
  assign mag   = dx[LAT-1][OW-1:0];
  assign phase = dy[LAT-1][OW-1:0];

  typedef struct {
    int            chan;
    logic [OW-1:0] mag;
    logic [OW-1:0] phase;
    int            due;
    int            issue;
  } exp_t;

  exp_t            q[$];
  int              checks = 0;
  int              errors = 0;
  int              cyc = 0;
  int              rr_m = 0;
  int              credit_m = DEPTH;
  int              last_grant = -1;
  int              gcount = 0;
  int              pop_lat = -1;
  int              pop_chan = -1;
  logic [OW-1:0]   pop_mag, pop_phase;
  logic [NREQ-1:0] vmask = '0;
  int              pct = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant();
    if (credit_m == 0) return -1;
    for (int off = 0; off < NREQ; off++) begin
      if (req_valid[(rr_m + off) % NREQ]) return (rr_m + off) % NREQ;
    end
    return -1;
  endfunction

  // One clock: check outputs mid-cycle against the model, advance the model,
  // then update requests while honouring valid/ready (held until granted).
  task automatic step();
    int   g;
    logic expv;
    exp_t e;
    @(negedge clk);
    g    = model_grant();
    expv = (q.size() > 0) && (q[0].due <= cyc);
    chk("ready", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
    chk("busy", 32'(busy), 32'(credit_m != DEPTH));
    chk("ce", 32'(ce), 32'd1);
    chk("res_valid", 32'(res_valid), 32'(expv));
    chk("no_overflow", 32'(dut.fifo_wr & dut.fifo_full), 32'd0);
    if (expv && res_ready) begin
      e = q.pop_front();
      chk("res_chan", 32'(res_chan), 32'(e.chan));
      chk("res_mag", 32'(res_mag), 32'(e.mag));
      chk("res_phase", 32'(res_phase), 32'(e.phase));
      pop_lat   = cyc - e.issue;
      pop_chan  = e.chan;
      pop_mag   = res_mag;
      pop_phase = res_phase;
      credit_m++;
    end
    last_grant = g;
    if (g >= 0) begin
      e.chan  = g;
      e.mag   = req_x[g*IW +: OW];
      e.phase = req_y[g*IW +: OW];
      e.issue = cyc;
      e.due   = cyc + 2 + LAT;
      q.push_back(e);
      rr_m = (g + 1) % NREQ;
      credit_m--;
      gcount++;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (g >= 0) req_valid[g] = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!req_valid[k] && vmask[k] && ($urandom_range(99) < pct)) begin
        req_valid[k]       = 1'b1;
        req_x[k*IW +: IW] = IW'($urandom);
        req_y[k*IW +: IW] = IW'($urandom);
      end
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    vmask     = '0;
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    q.delete();
    rr_m     = 0;
    credit_m = DEPTH;
  endtask

  task automatic drain();
    int n;
    vmask     = '0;
    res_ready = 1'b1;
    n = 0;
    while ((q.size() != 0 || req_valid != '0) && n < 400) begin
      step();
      n++;
    end
    chk("drain_empty", 32'(q.size()), 32'd0);
    step();
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_x     = '0;
    req_y     = '0;
    res_ready = 1'b1;

    // Reset state
    do_reset();
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cx", 32'(cx), 32'd0);
    chk("rst_cy", 32'(cy), 32'd0);
    chk("rst_ce", 32'(ce), 32'd1);

    // Single sample on channel 2
    req_x[2*IW +: IW] = 14'd100;
    req_y[2*IW +: IW] = -14'sd5;
    req_valid = 4'b0100;
    pop_lat = -1;
    step();
    chk("single_grant", 32'(last_grant), 32'd2);
    repeat (LAT + 4) step();
    chk("single_latency", 32'(pop_lat), 32'(LAT + 2));
    chk("single_chan", 32'(pop_chan), 32'd2);
    chk("single_mag", 32'(pop_mag), 32'd100);
    chk("single_phase", 32'(pop_phase), 32'h3FB);
    chk("single_idle", 32'(busy), 32'd0);

    // All channels streaming: strict rotation, one grant per cycle
    vmask = 4'b1111;
    pct   = 100;
    req_valid = 4'b1111;
    begin
      int prev;
      prev = -1;
      for (int i = 0; i < 24; i++) begin
        step();
        chk("all_grant_each_cycle", 32'(last_grant >= 0), 32'd1);
        if (prev >= 0) chk("all_rotation", 32'(last_grant), 32'((prev + 1) % NREQ));
        prev = last_grant;
      end
    end
    drain();

    // Backpressure: exactly DEPTH grants, then one more per pop
    res_ready = 1'b0;
    vmask     = 4'b0001;
    pct       = 100;
    req_valid = 4'b0001;
    gcount    = 0;
    repeat (DEPTH + LAT + 8) step();
    chk("bp_grants", 32'(gcount), 32'(DEPTH));
    res_ready = 1'b1;
    gcount    = 0;
    step();
    res_ready = 1'b0;
    repeat (6) step();
    chk("bp_one_more", 32'(gcount), 32'd1);
    drain();

    // Wrap-around: put rr_ptr at 2, then ch1+ch3 request
    req_valid = 4'b0010;
    step();
    chk("wrap_setup", 32'(last_grant), 32'd1);
    req_valid = 4'b1010;
    step();
    chk("wrap_first", 32'(last_grant), 32'd3);
    step();
    chk("wrap_second", 32'(last_grant), 32'd1);
    drain();

    // Reset with samples in flight: nothing may surface afterwards
    vmask     = 4'b1111;
    pct       = 100;
    req_valid = 4'b1111;
    gcount    = 0;
    repeat (10) step();
    chk("inflight_count", 32'(gcount), 32'd10);
    do_reset();
    chk("post_rst_credit", 32'(dut.credit_q), 32'(DEPTH));
    res_ready = 1'b1;
    repeat (LAT + 5) step();

    // Credit == 1 with issue and pop together every cycle
    res_ready = 1'b0;
    vmask     = 4'b0001;
    pct       = 100;
    req_valid = 4'b0001;
    repeat (DEPTH + LAT + 6) step();
    res_ready = 1'b1;
    step();
    gcount = 0;
    repeat (10) step();
    chk("credit1_grants", 32'(gcount), 32'd10);
    chk("credit1_value", 32'(dut.credit_q), 32'd1);
    drain();

    // Randomized traffic with random downstream backpressure
    vmask = 4'b1111;
    pct   = 40;
    for (int i = 0; i < 300; i++) begin
      res_ready = ($urandom_range(3) != 0);
      step();
    end
    drain();
    chk("final_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
